ucode_sequencer: RTL and testbench

Controller that sits between decode and execute and drives the microcode ROM for the multiply family (mul/muls, immediate and register forms). When decode presents a multiply instruction, the block captures its fields, stalls the front end, steps `ghost_pc` through the ROM sequence, and issues each micro-op to execute under a valid/ready handshake. It resolves micro-branches from execute feedback and detects the halt micro-op. Non-multiply instructions pass straight through to execute while the block is idle.

---
 rtl/ucode_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ucode_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ucode_sequencer
// Purpose  : Sequences the multiply-family microcode ROM between decode and
//            execute; pass-through for all other instructions while idle.
// Revision : 1.0 - initial release
// ============================================================================
module ucode_sequencer #(
  parameter int MAX_UOPS = 32,
  parameter int UPC_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      ucode_instr,
  output logic [6:0]       mul_opcode,
  output logic [15:0]      immediate,
  output logic [3:0]       reg1,
  output logic [3:0]       reg2,
  output logic [3:0]       dest_reg,
  output logic [UPC_W-1:0] ghost_pc,
  output logic [31:0]      issue_instr,
  output logic             issue_valid,
  input  logic             issue_ready,
  input  logic             br_resolve_valid,
  input  logic             br_taken,
  output logic             stall_fetch,
  output logic             seq_done,
  output logic             seq_error
);

  localparam int c_cnt_w = $clog2(MAX_UOPS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_BR_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [UPC_W-1:0]   r_pc;
  logic [UPC_W-1:0]   r_br_off;
  logic [c_cnt_w-1:0] r_cnt;
  logic [6:0]         r_opcode;
  logic [15:0]        r_imm;
  logic [3:0]         r_reg1;
  logic [3:0]         r_reg2;
  logic [3:0]         r_dest;
  logic               r_error;

  logic [6:0] w_op;
  logic       w_is_mul;
  logic       w_halt;
  logic       w_branch;
  logic       w_wdog;
  logic       w_pc_last;

  assign w_op      = instr_in[31:25];
  assign w_is_mul  = (w_op == 7'b0010000) || (w_op == 7'b0011000) ||
                     (w_op == 7'b0110000) || (w_op == 7'b0111000);
  assign w_halt    = (ucode_instr[31:28] == 4'b1101);
  assign w_branch  = (ucode_instr[31:25] == 7'b1100001);
  assign w_wdog    = (r_cnt == c_cnt_w'(MAX_UOPS));
  assign w_pc_last = &r_pc;

  // Idle is transparent to execute; in ISSUE the ROM word is the payload and
  // a halt (or a watchdog abort) is never presented as valid.
  always_comb begin
    issue_instr = ucode_instr;
    issue_valid = 1'b0;
    instr_ready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        issue_instr = instr_in;
        issue_valid = instr_valid & ~w_is_mul;
        instr_ready = w_is_mul | issue_ready;
      end
      ST_ISSUE: issue_valid = ~w_halt & ~w_wdog;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_br_off <= '0;
      r_cnt    <= '0;
      r_opcode <= '0;
      r_imm    <= '0;
      r_reg1   <= '0;
      r_reg2   <= '0;
      r_dest   <= '0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (instr_valid && w_is_mul) begin
            r_opcode <= w_op;
            r_dest   <= instr_in[24:21];
            r_reg1   <= instr_in[20:17];
            r_reg2   <= instr_in[16:13];
            r_imm    <= instr_in[15:0];
            r_pc     <= '0;
            r_cnt    <= '0;
            r_state  <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_ISSUE;
        ST_ISSUE: begin
          if (w_wdog) begin
            r_error <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_halt) begin
            r_state <= ST_DONE;
          end else if (issue_ready) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_branch) begin
              // Offset is latched so BR_WAIT does not depend on the ROM port.
              r_br_off <= ucode_instr[UPC_W-1:0];
              r_state  <= ST_BR_WAIT;
            end else if (w_pc_last) begin
              r_error <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_pc    <= r_pc + UPC_W'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_BR_WAIT: begin
          if (br_resolve_valid) begin
            if (br_taken) begin
              r_pc    <= r_pc + r_br_off;
              r_state <= ST_FETCH;
            end else if (w_pc_last) begin
              r_error <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_pc    <= r_pc + UPC_W'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_opcode <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mul_opcode  = r_opcode;
  assign immediate   = r_imm;
  assign reg1        = r_reg1;
  assign reg2        = r_reg2;
  assign dest_reg    = r_dest;
  assign ghost_pc    = r_pc;
  assign seq_error   = r_error;
  assign seq_done    = (r_state == ST_DONE);
  assign stall_fetch = (r_state == ST_FETCH) || (r_state == ST_ISSUE) ||
                       (r_state == ST_BR_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucode_sequencer
// Purpose  : Self-checking bench for ucode_sequencer with a ROM model and a
//            program-level reference of the expected micro-op stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

  localparam int MAX_UOPS = 32;
  localparam int UPC_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      ucode_instr = 32'h0;
  logic [6:0]       mul_opcode;
  logic [15:0]      immediate;
  logic [3:0]       reg1, reg2, dest_reg;
  logic [UPC_W-1:0] ghost_pc;
  logic [31:0]      issue_instr;
  logic             issue_valid;
  logic             issue_ready;
  logic             br_resolve_valid;
  logic             br_taken;
  logic             stall_fetch;
  logic             seq_done;
  logic             seq_error;

  ucode_sequencer #(.MAX_UOPS(MAX_UOPS), .UPC_W(UPC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ucode_instr(ucode_instr), .mul_opcode(mul_opcode), .immediate(immediate),
    .reg1(reg1), .reg2(reg2), .dest_reg(dest_reg), .ghost_pc(ghost_pc),
    .issue_instr(issue_instr), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .br_resolve_valid(br_resolve_valid), .br_taken(br_taken),
    .stall_fetch(stall_fetch), .seq_done(seq_done), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [16];
  bit          br_out [64];
  int          br_idx;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic        err_exp = 1'b0;
  int          exp_pc [$];
  logic        m_err;
  int          m_final_pc;

  always @(posedge clk) begin
    ucode_instr <= rom[ghost_pc];
    cyc         <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Walks the ROM program by the architectural rules to list issued addresses.
  task automatic build_model();
    int pc, n, bi, p;
    logic [31:0] w;
    exp_pc.delete();
    m_err = 1'b0;
    pc = 0; n = 0; bi = br_idx;
    for (int g = 0; g < 200; g++) begin
      if (n == MAX_UOPS) begin m_err = 1'b1; break; end
      w = rom[pc];
      if (w[31:28] == 4'hD) break;
      exp_pc.push_back(pc);
      n++;
      if (w[31:25] == 7'h61) begin
        bi++;
        if (br_out[bi-1]) begin
          p = pc + int'(w[15:0]);
          if (w[15]) p = p - 65536;
          pc = ((p % 16) + 16) % 16;
          continue;
        end
      end
      if (pc == 15) begin m_err = 1'b1; break; end
      pc++;
    end
    m_final_pc = pc;
  endtask

  task automatic run_seq(input logic [31:0] mi, input bit rnd, input bit timing, input bit offer_done);
    int cap, k, done_cyc, br_dly;
    bit br_pend, done;
    int iss_cyc [$];
    build_model();
    err_exp = err_exp | m_err;
    @(negedge clk);
    instr_in = mi; instr_valid = 1'b1; issue_ready = 1'b0; br_resolve_valid = 1'b0;
    #1;
    chk("mul_accept", instr_ready, 1);
    chk("mul_not_passed", issue_valid, 0);
    chk("opcode_idle", mul_opcode, 0);
    cap = cyc; k = 0; done = 0; done_cyc = 0; br_pend = 0; br_dly = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (t == 0) begin instr_valid = 1'b0; instr_in = $urandom; end
      issue_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (br_resolve_valid) br_resolve_valid = 1'b0;
      else if (br_pend) begin
        if (br_dly == 0) begin
          br_resolve_valid = 1'b1; br_taken = br_out[br_idx]; br_idx++; br_pend = 0;
        end else br_dly--;
      end
      #1;
      if (t == 0) begin
        chk("cap_opcode", mul_opcode, mi[31:25]);
        chk("cap_imm", immediate, mi[15:0]);
        chk("cap_reg1", reg1, mi[20:17]);
        chk("cap_reg2", reg2, mi[16:13]);
        chk("cap_dest", dest_reg, mi[24:21]);
        chk("fetch_stall", stall_fetch, 1);
      end
      if (stall_fetch && issue_valid) begin
        if (k < exp_pc.size()) begin
          chk("issue_pc", ghost_pc, exp_pc[k]);
          chk("issue_instr", issue_instr, rom[exp_pc[k]]);
        end else chk("extra_issue", k, exp_pc.size());
        if (issue_ready) begin
          iss_cyc.push_back(cyc);
          if (issue_instr[31:25] == 7'h61) begin
            br_pend = 1; br_dly = rnd ? $urandom_range(0, 3) : 0;
          end
          k++;
        end
      end
      if (seq_done) begin done = 1; done_cyc = cyc; end
    end
    chk("seq_done_seen", done, 1);
    chk("issue_count", k, exp_pc.size());
    chk("done_pc", ghost_pc, m_final_pc);
    chk("done_stall", stall_fetch, 0);
    chk("seq_error", seq_error, err_exp);
    if (timing) begin
      for (int i = 0; i < iss_cyc.size(); i++) chk("issue_cycle", iss_cyc[i] - cap, 2 + 2 * i);
      chk("done_cycle", done_cyc - cap, 2 * k + 3);
    end
    if (offer_done) begin
      instr_in = mi; instr_valid = 1'b1;
      #1;
      chk("ready_in_done", instr_ready, 0);
    end
  endtask

  task automatic load_straight();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0100_0000 + 32'(i * 32'h111);
    rom[5] = 32'hD000_0000;
  endtask

  initial begin
    logic [31:0] pt;
    logic [31:0] mops [4];
    mops[0] = 32'h2000_0000; mops[1] = 32'h3000_0000;
    mops[2] = 32'h6000_0000; mops[3] = 32'h7000_0000;
    for (int i = 0; i < 64; i++) br_out[i] = 1'b0;
    br_idx = 0;
    load_straight();
    rst_n = 1'b0; instr_in = 32'h0; instr_valid = 1'b0; issue_ready = 1'b1;
    br_resolve_valid = 1'b0; br_taken = 1'b0;
    #3;
    chk("rst_pc", ghost_pc, 0);
    chk("rst_opcode", mul_opcode, 0);
    chk("rst_imm", immediate, 0);
    chk("rst_fields", {reg1, reg2, dest_reg}, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_stall", stall_fetch, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_error", seq_error, 0);
    chk("rst_ready_hi", instr_ready, 1);
    issue_ready = 1'b0;
    #1;
    chk("rst_ready_lo", instr_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Pass-through of non-multiply opcodes
    @(negedge clk);
    pt = 32'h02AB_CDEF; instr_in = pt; instr_valid = 1'b1; issue_ready = 1'b1;
    #1;
    chk("pt_valid", issue_valid, 1);
    chk("pt_instr", issue_instr, pt);
    chk("pt_ready", instr_ready, 1);
    issue_ready = 1'b0;
    #1;
    chk("pt_ready_bp", instr_ready, 0);
    chk("pt_valid_bp", issue_valid, 1);
    @(negedge clk);
    pt = 32'h2200_1234; instr_in = pt; issue_ready = 1'b1;
    #1;
    chk("pt_near_mul", issue_valid, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("pt_stall", stall_fetch, 0);
    chk("pt_pc", ghost_pc, 0);

    // Straight-line sequence, then a multiply offered during DONE
    run_seq(32'h20A4_C3F5, 1'b0, 1'b1, 1'b1);
    run_seq(32'h20A4_C3F5, 1'b1, 1'b0, 1'b0);

    // Loop: taken, taken, not taken
    load_straight();
    rom[4] = 32'hC200_FFFD;
    br_out[0] = 1; br_out[1] = 1; br_out[2] = 0; br_idx = 0;
    run_seq(32'h3123_4567, 1'b0, 1'b0, 1'b0);

    // Random programs with random backpressure and resolve latency
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: rom[i] = {4'h1, 28'($urandom)};
          6, 7:             rom[i] = {7'h61, 9'h0, 16'($urandom_range(0, 65535))};
          8:                rom[i] = 32'hD000_0000;
          default:          rom[i] = $urandom;
        endcase
      end
      for (int i = 0; i < 64; i++) br_out[i] = 1'($urandom);
      br_idx = 0;
      run_seq(mops[$urandom_range(0, 3)] | ($urandom & 32'h01FF_FFFF), 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset while waiting on a branch outcome
    load_straight();
    rom[2] = 32'hC200_0000;
    @(negedge clk);
    instr_in = 32'h7005_1234; instr_valid = 1'b1; issue_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        #1;
        if (stall_fetch && issue_valid && issue_instr[31:25] == 7'h61) seen = 1;
      end
      chk("rst_test_branch_seen", seen, 1);
    end
    @(negedge clk);
    #1;
    chk("brwait_pc", ghost_pc, 2);
    chk("brwait_stall", stall_fetch, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", stall_fetch, 0);
    chk("arst_pc", ghost_pc, 0);
    chk("arst_opcode", mul_opcode, 0);
    chk("arst_imm", immediate, 0);
    chk("arst_valid", issue_valid, 0);
    chk("arst_error", seq_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    err_exp = 1'b0;
    rom[2] = 32'h0100_0222;
    run_seq(32'h7005_1234, 1'b0, 1'b1, 1'b0);

    // Watchdog: branch to itself, always taken
    load_straight();
    rom[0] = 32'hC200_0000;
    for (int i = 0; i < 64; i++) br_out[i] = 1'b1;
    br_idx = 0;
    run_seq(32'h6000_00FF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("error_sticky", seq_error, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("error_cleared", seq_error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
